// File: rtl/mem_rw_arbiter.sv
// Write/read arbiter in front of a single-port synchronous memory.
// Round-robin on conflict, one read in flight, and a held read response.
module mem_rw_arbiter #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RD_CAP = 1'b1
   } state_t;

   localparam logic GRANT_READ  = 1'b0;
   localparam logic GRANT_WRITE = 1'b1;

   state_t                state_r;
   state_t                state_s;
   logic                  last_grant_r;
   logic                  rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_data_r;
   logic                  rd_elig_s;
   logic                  grant_wr_s;
   logic                  grant_rd_s;

   // Grant selection, next state and memory-side drive.
   always_comb begin
      state_s     = state_r;
      grant_wr_s  = 1'b0;
      grant_rd_s  = 1'b0;
      rd_elig_s   = rd_valid && (state_r == IDLE) && !rsp_valid_r;

      if (!RSTn) begin
         grant_wr_s = 1'b0;
         grant_rd_s = 1'b0;
      end else if (wr_valid && rd_elig_s) begin
         if (last_grant_r == GRANT_READ) begin
            grant_wr_s = 1'b1;
         end else begin
            grant_rd_s = 1'b1;
         end
      end else if (wr_valid) begin
         grant_wr_s = 1'b1;
      end else if (rd_elig_s) begin
         grant_rd_s = 1'b1;
      end else begin
         grant_wr_s = 1'b0;
         grant_rd_s = 1'b0;
      end

      case (state_r)
         IDLE: begin
            if (grant_rd_s) begin
               state_s = RD_CAP;
            end else begin
               state_s = IDLE;
            end
         end
         RD_CAP:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign wr_ready    = grant_wr_s;
   assign rd_ready    = grant_rd_s;
   assign mem_wr_en   = grant_wr_s;
   assign mem_addr    = grant_wr_s ? wr_addr : rd_addr;
   assign mem_wr_data = wr_data;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_data    = rsp_data_r;

   // State register and round-robin history.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_READ;
      end else begin
         state_r <= state_s;
         if (grant_wr_s) begin
            last_grant_r <= GRANT_WRITE;
         end else if (grant_rd_s) begin
            last_grant_r <= GRANT_READ;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Response capture (memory data is valid in RD_CAP) and hold until consumed.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {DATA_WIDTH{1'b0}};
      end else if (state_r == RD_CAP) begin
         rsp_valid_r <= 1'b1;
         rsp_data_r  <= mem_rd_data;
      end else if (rsp_valid_r && rsp_ready) begin
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= rsp_data_r;
      end else begin
         rsp_valid_r <= rsp_valid_r;
         rsp_data_r  <= rsp_data_r;
      end
   end

endmodule

// File: tb/tb_mem_rw_arbiter.sv
// Directed bench for mem_rw_arbiter with a behavioural single-port memory.
module tb_mem_rw_arbiter;
   localparam int AW = 6;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RSTn;
   logic          wr_valid, rd_valid, rsp_ready;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready, rd_ready, rsp_valid, mem_wr_en;
   logic [DW-1:0] rsp_data, mem_wr_data;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mem_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   // Single-port memory: a write leaves the registered read data untouched.
   always @(posedge CLK) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      else           mem_rd_data   <= mem[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RSTn = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      cyc(); cyc();
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_data", rsp_data, 32'h0);
      wr_valid = 1'b1; rd_valid = 1'b1; #1;
      check_eq("rst_wr_ready", wr_ready, 1'b0);
      check_eq("rst_rd_ready", rd_ready, 1'b0);
      check_eq("rst_mem_wr_en", mem_wr_en, 1'b0);
      wr_valid = 1'b0; rd_valid = 1'b0;
      RSTn = 1'b1;

      // 1: write then read back
      cyc();
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF; #1;
      check_eq("t1_wr_ready", wr_ready, 1'b1);
      check_eq("t1_mem_wr_en", mem_wr_en, 1'b1);
      check_eq("t1_mem_addr", mem_addr, 6'd5);
      check_eq("t1_mem_wr_data", mem_wr_data, 32'hDEADBEEF);
      cyc();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 6'd5; #1;
      check_eq("t1_rd_ready", rd_ready, 1'b1);
      check_eq("t1_rd_mem_wr_en", mem_wr_en, 1'b0);
      check_eq("t1_rd_mem_addr", mem_addr, 6'd5);
      cyc();
      rd_valid = 1'b0;
      check_eq("t1_rsp_t1", rsp_valid, 1'b0);
      cyc();
      check_eq("t1_rsp_valid", rsp_valid, 1'b1);
      check_eq("t1_rsp_data", rsp_data, 32'hDEADBEEF);
      cyc();
      check_eq("t1_rsp_drop", rsp_valid, 1'b0);
      check_eq("t1_rsp_keep", rsp_data, 32'hDEADBEEF);

      // 2: conflict after reset, write wins
      RSTn = 1'b0; cyc(); RSTn = 1'b1; cyc();
      wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 32'h11111111;
      rd_valid = 1'b1; rd_addr = 6'd3; #1;
      check_eq("t2_wr_first", wr_ready, 1'b1);
      check_eq("t2_rd_wait", rd_ready, 1'b0);
      cyc();
      wr_valid = 1'b0; #1;
      check_eq("t2_rd_next", rd_ready, 1'b1);
      cyc();
      rd_valid = 1'b0;
      cyc();
      check_eq("t2_rsp_valid", rsp_valid, 1'b1);
      check_eq("t2_rsp_data", rsp_data, 32'h11111111);
      cyc();

      // 3: last grant WRITE, conflict -> read wins
      wr_valid = 1'b1; wr_addr = 6'd7; wr_data = 32'h77777777; #1;
      check_eq("t3_pre_wr", wr_ready, 1'b1);
      cyc();
      wr_addr = 6'd3; wr_data = 32'h22222222;
      rd_valid = 1'b1; rd_addr = 6'd3; #1;
      check_eq("t3_rd_first", rd_ready, 1'b1);
      check_eq("t3_wr_wait", wr_ready, 1'b0);
      cyc();
      rd_valid = 1'b0; #1;
      check_eq("t3_wr_next", wr_ready, 1'b1);
      check_eq("t3_wr_en_next", mem_wr_en, 1'b1);
      cyc();
      wr_valid = 1'b0;
      check_eq("t3_rsp_valid", rsp_valid, 1'b1);
      check_eq("t3_rsp_old", rsp_data, 32'h11111111);
      cyc();

      // 4: response held under back-pressure, write in between
      rsp_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 6'd5; #1;
      check_eq("t4_rd_ready", rd_ready, 1'b1);
      cyc();
      rd_valid = 1'b0;
      wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 32'hCAFEF00D; #1;
      check_eq("t4_wr_ready", wr_ready, 1'b1);
      cyc();
      wr_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_valid = 1'b1; rd_addr = 6'd5; #1;
         check_eq("t4_hold_valid", rsp_valid, 1'b1);
         check_eq("t4_hold_data", rsp_data, 32'hDEADBEEF);
         check_eq("t4_rd_blocked", rd_ready, 1'b0);
         cyc();
      end
      rd_valid = 1'b0; rsp_ready = 1'b1;
      cyc();
      check_eq("t4_rsp_drop", rsp_valid, 1'b0);
      rd_valid = 1'b1; rd_addr = 6'd5; #1;
      check_eq("t4_rd2_ready", rd_ready, 1'b1);
      cyc();
      rd_valid = 1'b0;
      cyc();
      check_eq("t4_rd2_valid", rsp_valid, 1'b1);
      check_eq("t4_rd2_data", rsp_data, 32'hCAFEF00D);
      cyc();

      // 5: write granted during RD_CAP, captured data is the read value
      rd_valid = 1'b1; rd_addr = 6'd3; #1;
      check_eq("t5_rd_ready", rd_ready, 1'b1);
      cyc();
      rd_valid = 1'b0;
      wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 32'h33333333; #1;
      check_eq("t5_cap_wr_en", mem_wr_en, 1'b1);
      check_eq("t5_cap_wr_ready", wr_ready, 1'b1);
      cyc();
      wr_valid = 1'b0;
      check_eq("t5_rsp_valid", rsp_valid, 1'b1);
      check_eq("t5_rsp_data", rsp_data, 32'h22222222);
      cyc();
      rd_valid = 1'b1; rd_addr = 6'd3; #1;
      cyc();
      rd_valid = 1'b0;
      cyc();
      check_eq("t5_new_data", rsp_data, 32'h33333333);
      cyc();

      // 6: reset during RD_CAP and while a response is pending
      rd_valid = 1'b1; rd_addr = 6'd5; #1;
      cyc();
      rd_valid = 1'b0;
      RSTn = 1'b0; #1;
      check_eq("t6a_rsp_valid", rsp_valid, 1'b0);
      check_eq("t6a_rsp_data", rsp_data, 32'h0);
      cyc();
      RSTn = 1'b1;
      cyc(); cyc();
      check_eq("t6a_no_spurious", rsp_valid, 1'b0);
      rsp_ready = 1'b0;
      rd_valid = 1'b1; rd_addr = 6'd5; #1;
      check_eq("t6b_rd_ready", rd_ready, 1'b1);
      cyc();
      rd_valid = 1'b0;
      cyc();
      check_eq("t6b_rsp_valid", rsp_valid, 1'b1);
      check_eq("t6b_rsp_data", rsp_data, 32'hCAFEF00D);
      RSTn = 1'b0; #1;
      check_eq("t6b_rst_valid", rsp_valid, 1'b0);
      check_eq("t6b_rst_data", rsp_data, 32'h0);
      cyc();
      RSTn = 1'b1;
      cyc(); cyc();
      check_eq("t6b_no_spurious", rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
